// File: rtl/lfsr_n.sv
// lfsr_n: parametrised Fibonacci LFSR with load, zero-lock recovery and period measurement
module lfsr_n #(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = 7'h44,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] data_out,
  output logic             seed_hit,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             lock_err
);
  logic [WIDTH-1:0] state_q, state_d, cnt_q, cnt_d, period_q, period_d, nxt;
  logic             hit_q, hit_d, pv_q, pv_d, lock_q, lock_d;
  // next-state: load wins over a step; a zero load is replaced by SEED and flagged
  always_comb begin
    nxt      = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    pv_d     = pv_q;
    lock_d   = lock_q;
    hit_d    = 1'b0;
    if (load) begin
      state_d = load_val == '0 ? SEED : load_val;
      lock_d  = lock_q | (load_val == '0);
      cnt_d   = '0;
      pv_d    = 1'b0;
    end else if (en) begin
      state_d = nxt;
      if (nxt == SEED) begin
        hit_d    = 1'b1;
        period_d = cnt_q + WIDTH'(1);
        pv_d     = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + WIDTH'(1);
      end
    end
  end
  // state registers with synchronous reset to SEED
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      hit_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      hit_q    <= hit_d;
      lock_q   <= lock_d;
    end
  end
  assign data_out     = state_q;
  assign seed_hit     = hit_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign lock_err     = lock_q;
endmodule

// File: tb/tb_lfsr_n.sv
// tb_lfsr_n: randomized and directed checks of lfsr_n against a behavioural model
module tb_lfsr_n;
  logic       clk = 0, rst = 0, en = 0, load = 0;
  logic [6:0] load_val = '0;
  logic [6:0] d_data, d_per;
  logic       d_hit, d_pv, d_lock;
  logic [3:0] w_data, w_per;
  logic       w_hit, w_pv, w_lock;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  lfsr_n dut7 (.clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .data_out(d_data), .seed_hit(d_hit), .period(d_per), .period_valid(d_pv), .lock_err(d_lock));
  lfsr_n #(.WIDTH(4), .TAPS(4'b1010), .SEED(4'd1)) dut4 (.clk(clk), .rst(rst), .en(en), .load(load),
    .load_val(load_val[3:0]), .data_out(w_data), .seed_hit(w_hit), .period(w_per),
    .period_valid(w_pv), .lock_err(w_lock));

  // model: index 0 = 7-bit default generator, index 1 = 4-bit generator
  int  mw[2] = '{7, 4};
  int  mt[2] = '{'h44, 'hA};
  int  ms[2], mc[2], mp[2];
  bit  mh[2], mv[2], ml[2];

  function automatic int lfsr_next(int s, int t, int w);
    return ((s << 1) | ($countones(s & t) % 2)) & ((1 << w) - 1);
  endfunction

  function automatic logic [29:0] expv();
    return {ms[0][6:0], mh[0], mp[0][6:0], mv[0], ml[0],
            ms[1][3:0], mh[1], mp[1][3:0], mv[1], ml[1]};
  endfunction

  wire [29:0] actv = {d_data, d_hit, d_per, d_pv, d_lock, w_data, w_hit, w_per, w_pv, w_lock};

  task automatic step(input bit r, input bit l, input bit e, input logic [6:0] lv);
    rst = r; load = l; en = e; load_val = lv;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int v = int'(lv) & ((1 << mw[k]) - 1);
      int n = lfsr_next(ms[k], mt[k], mw[k]);
      mh[k] = 0;
      if (r) begin
        ms[k] = 1; mc[k] = 0; mp[k] = 0; mv[k] = 0; ml[k] = 0;
      end else if (l) begin
        ms[k] = (v == 0) ? 1 : v; ml[k] = ml[k] | (v == 0); mc[k] = 0; mv[k] = 0;
      end else if (e) begin
        ms[k] = n;
        if (n == 1) begin
          mh[k] = 1; mp[k] = mc[k] + 1; mv[k] = 1; mc[k] = 0;
        end else if (mc[k] < (1 << mw[k]) - 1) mc[k]++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 7'h33);
    checks++;
    if (actv !== expv() || {d_data, d_hit, d_per, d_pv, d_lock} !== {7'h01, 1'b0, 7'h00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset act=%h exp=%h", actv, expv());
    end
  endtask

  task automatic test_default_run();
    logic [6:0] seq[8] = '{7'h01, 7'h02, 7'h04, 7'h09, 7'h12, 7'h24, 7'h49, 7'h13};
    int hits = 0;
    step(1, 0, 0, 0);
    checks++;
    if (d_data !== seq[0]) begin errors++; $display("FAIL seq0 act=%h exp=%h", d_data, seq[0]); end
    for (int i = 1; i <= 127; i++) begin
      step(0, 0, 1, 0);
      hits += d_hit;
      checks++;
      if (actv !== expv()) begin errors++; $display("FAIL run step %0d act=%h exp=%h", i, actv, expv()); end
      if (i < 8) begin
        checks++;
        if (d_data !== seq[i]) begin errors++; $display("FAIL seq%0d act=%h exp=%h", i, d_data, seq[i]); end
      end
    end
    checks++;
    if ({d_data, d_hit, d_per, d_pv} !== {7'h01, 1'b1, 7'd127, 1'b1} || hits != 1) begin
      errors++; $display("FAIL wrap127 data=%h hit=%b per=%0d pv=%b hits=%0d exp 01 1 127 1 1", d_data, d_hit, d_per, d_pv, hits);
    end
  endtask

  task automatic test_width4();
    logic [3:0] seq[6] = '{4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h1};
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0);
      checks++;
      if (w_data !== seq[i] || w_hit !== (i == 5)) begin
        errors++; $display("FAIL w4 step %0d act=%h hit=%b exp=%h hit=%b", i + 1, w_data, w_hit, seq[i], i == 5);
      end
    end
    checks++;
    if ({w_per, w_pv} !== {4'd6, 1'b1}) begin errors++; $display("FAIL w4 period act=%0d/%b exp=6/1", w_per, w_pv); end
  endtask

  task automatic test_lock();
    step(1, 0, 0, 0);
    for (int i = 0; i < 127; i++) step(0, 0, 1, 0);
    step(0, 1, 1, 7'h00);
    checks++;
    if ({d_data, d_lock, d_pv, d_hit, d_per} !== {7'h01, 1'b1, 1'b0, 1'b0, 7'd127} || actv !== expv()) begin
      errors++; $display("FAIL lock load act=%h exp=%h", actv, expv());
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 0);
      checks++;
      if (d_lock !== 1'b1 || actv !== expv()) begin errors++; $display("FAIL lock sticky act=%h exp=%h", actv, expv()); end
    end
    step(1, 0, 0, 0);
    checks++;
    if (d_lock !== 1'b0) begin errors++; $display("FAIL lock clear act=%b exp=0", d_lock); end
  endtask

  task automatic test_load_en();
    step(0, 1, 1, 7'h55);
    checks++;
    if (d_data !== 7'h55 || d_hit !== 1'b0 || actv !== expv()) begin
      errors++; $display("FAIL load55 act=%h exp=%h", actv, expv());
    end
    step(0, 0, 1, 0);
    step(0, 1, 1, 7'h01);
    checks++;
    if (d_data !== 7'h01 || d_hit !== 1'b0 || w_hit !== 1'b0) begin
      errors++; $display("FAIL loadseed data=%h hit=%b/%b exp 01 0/0", d_data, d_hit, w_hit);
    end
  endtask

  task automatic test_toggle();
    logic [6:0] exp[4] = '{7'h02, 7'h02, 7'h02, 7'h04};
    bit         ens[4] = '{1, 0, 0, 1};
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, ens[i], 0);
      checks++;
      if (d_data !== exp[i] || d_hit !== 1'b0) begin errors++; $display("FAIL toggle %0d act=%h exp=%h", i, d_data, exp[i]); end
    end
    for (int i = 0; i < 125; i++) step(0, 0, 1, 0);
    checks++;
    if ({d_data, d_hit, d_per, d_pv} !== {7'h01, 1'b1, 7'd127, 1'b1}) begin
      errors++; $display("FAIL toggle wrap data=%h hit=%b per=%0d pv=%b exp 01 1 127 1", d_data, d_hit, d_per, d_pv);
    end
  endtask

  task automatic test_rst_mid();
    step(1, 0, 0, 0);
    for (int i = 0; i < 50; i++) step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    checks++;
    if ({d_data, d_hit, d_per, d_pv, d_lock} !== {7'h01, 1'b0, 7'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst mid act=%h exp=01/0/00/0/0", {d_data, d_hit, d_per, d_pv, d_lock});
    end
    for (int i = 0; i < 127; i++) step(0, 0, 1, 0);
    checks++;
    if ({d_data, d_hit, d_per, d_pv} !== {7'h01, 1'b1, 7'd127, 1'b1}) begin
      errors++; $display("FAIL rst rerun data=%h per=%0d pv=%b exp 01 127 1", d_data, d_per, d_pv);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      int  r = $urandom_range(0, 999);
      step(r < 3, r >= 3 && r < 25, $urandom_range(0, 9) < 8,
           $urandom_range(0, 3) == 0 ? 7'h00 : 7'($urandom));
      checks++;
      if (actv !== expv()) begin errors++; $display("FAIL random cyc %0d act=%h exp=%h", i, actv, expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_width4();
    test_lock();
    test_load_en();
    test_toggle();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lfsr_n.md
# lfsr_n

Parametrised Fibonacci LFSR, the general successor to the fixed 7-bit generator. It provides run-time state loading, zero-state lock-up protection and on-chip period measurement. It sits beside the FSM and display logic as a configurable pseudo-random source. It also serves as a self-checking tap-polynomial tester, because it reports the measured cycle length of the programmed taps.

## Interface
Parameters:
- WIDTH, 7, state width in bits; legal range 3..32.
- TAPS, 7'h44, WIDTH-bit feedback mask; bit i set means state[i] enters the XOR. The default selects bits 6 and 2.
- SEED, 1, WIDTH-bit reset/recovery state; must be non-zero.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance the state by one step this cycle.
- load  in  1  replace the state with load_val this cycle.
- load_val  in  WIDTH  value to load.
- data_out  out  WIDTH  current LFSR state (registered).
- seed_hit  out  1  one-cycle pulse: a step has just returned the state to SEED.
- period  out  WIDTH  step count of the last completed SEED-to-SEED cycle.
- period_valid  out  1  period holds a valid measurement.
- lock_err  out  1  sticky flag: an all-zero load was attempted.

## Operation
- Step function: next = {state[WIDTH-2:0], ^(state & TAPS)}. The shift is toward the MSB and the feedback enters at the LSB.
- Priority per cycle: rst > load > en > hold.
- rst:
  - state = SEED, step_cnt = 0, period = 0.
  - period_valid = 0, seed_hit = 0, lock_err = 0.
- load with load_val != 0:
  - state = load_val, step_cnt = 0, period_valid = 0.
  - period is held unchanged.
  - No step occurs, even if en = 1.
- load with load_val == 0:
  - state = SEED and lock_err = 1. The flag stays set until rst.
  - step_cnt = 0 and period_valid = 0.
- en (no load): state = next.
  - If next == SEED: seed_hit = 1, period = step_cnt + 1, period_valid = 1, step_cnt = 0.
  - Otherwise: step_cnt increments, saturating at all-ones. Saturation happens when the loaded value lies on a cycle that never contains SEED.
- en = 0 and no load: state, step_cnt, period and flags hold. seed_hit = 0.
- The all-zero state is unreachable. Reset and recovery force SEED, and the XOR feedback cannot map a non-zero state to zero.
- step_cnt is internal, WIDTH bits wide. The maximum period 2^WIDTH - 1 fits without overflow.

## Timing
- All outputs are registered. Every change appears the cycle after the qualifying edge.
- data_out reflects a step, load or reset one clock after the edge that sampled it.
- seed_hit is high in exactly the cycle where data_out first shows SEED after a step. It is never high after rst or load, even when load_val == SEED.
- period and period_valid update in the same cycle as seed_hit.
- lock_err rises in the same cycle that data_out shows the substituted SEED.
- Back-to-back en steps every cycle; no bubbles.
- rst mid-sequence abandons the cycle count. No seed_hit is generated.

## Test plan
- Default parameters, rst then en held high:
  - data_out = 01, 02, 04, 09, 12, 24, 49, 13 over the first steps.
  - After 127 steps: data_out = 01, seed_hit pulses once, period = 127, period_valid = 1.
- WIDTH=4, TAPS=4'b1010, SEED=1, en high:
  - Sequence is 1, 2, 5, A, 4, 8, 1.
  - seed_hit is asserted on the 6th step and period = 6.
- load = 1 with load_val = 0:
  - Next cycle data_out = SEED, lock_err = 1, period_valid = 0.
  - lock_err stays 1 through further steps until rst.
- load and en high together, load_val = 7'h55: data_out = 55 next cycle with no step applied, seed_hit = 0.
- en toggled 1,0,0,1 from reset: data_out = 02, 02, 02, 04, and the count still yields period = 127 at wrap.
- rst asserted after 50 steps:
  - Next cycle data_out = SEED with all flags 0 and period = 0.
  - A full 127-step run afterwards reports period = 127.
